// File: rtl/logic_op_pipe_pkg.sv
// Shared types and the combinational operation for logic_op_pipe.
// Operands wider than LOGIC_OP_MAX_WIDTH are not supported by logic_op_apply.
package logic_op_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_OR   = 2'd1,
    OP_XOR  = 2'd2,
    OP_NAND = 2'd3
  } logic_op_e;

  localparam int LOGIC_OP_MAX_WIDTH = 64;

  // Callers zero-extend operands to the maximum width and truncate the result back.
  function automatic logic [LOGIC_OP_MAX_WIDTH-1:0] logic_op_apply(
    input logic_op_e                     op,
    input logic [LOGIC_OP_MAX_WIDTH-1:0] a,
    input logic [LOGIC_OP_MAX_WIDTH-1:0] b
  );
    logic [LOGIC_OP_MAX_WIDTH-1:0] res;
    res = '0;
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/logic_op_pipe_if.sv
// Operand/result bus of logic_op_pipe.
// z_par exists only when LOGIC_OP_PIPE_PARITY_EN is defined.
interface logic_op_if #(
  parameter int WIDTH = 8
);
  import logic_op_pkg::*;

  logic             in_valid;
  logic_op_e        op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] z;
  logic             out_valid;
`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic             z_par;

  modport master (output in_valid, op, a, b, input z, out_valid, z_par);
  modport slave  (input in_valid, op, a, b, output z, out_valid, z_par);
`else
  modport master (output in_valid, op, a, b, input z, out_valid);
  modport slave  (input in_valid, op, a, b, output z, out_valid);
`endif

endinterface

// File: rtl/logic_op_pipe_stage.sv
// One pipeline stage: data register that loads only on a valid beat, plus its valid bit.
// Parity bit (LOGIC_OP_PIPE_PARITY_EN) follows the data register exactly.
module logic_op_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
`ifdef LOGIC_OP_PIPE_PARITY_EN
  input  logic             p_in,
  output logic             p_out,
`endif
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);

  // Flush clears only the valid bit; data holds so z keeps the last valid result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out <= '0;
      v_out <= 1'b0;
`ifdef LOGIC_OP_PIPE_PARITY_EN
      p_out <= 1'b0;
`endif
    end else if (flush) begin
      v_out <= 1'b0;
    end else if (enable) begin
      v_out <= v_in;
      if (v_in) begin
        d_out <= d_in;
`ifdef LOGIC_OP_PIPE_PARITY_EN
        p_out <= p_in;
`endif
      end
    end
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Fixed-latency, stallable bitwise AND/OR/XOR/NAND pipeline of DEPTH stages.
// Optional even parity of z via LOGIC_OP_PIPE_PARITY_EN.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       flush,
  logic_op_if.slave  bus
);

  logic [DEPTH:0][WIDTH-1:0] stage_d;
  logic [DEPTH:0]            stage_v;

  // Index 0 is the combinational input beat; index k is the output of stage k.
  assign stage_d[0] = WIDTH'(logic_op_apply(bus.op,
                                            LOGIC_OP_MAX_WIDTH'(bus.a),
                                            LOGIC_OP_MAX_WIDTH'(bus.b)));
  assign stage_v[0] = bus.in_valid;

`ifdef LOGIC_OP_PIPE_PARITY_EN
  logic [DEPTH:0] stage_p;
  assign stage_p[0] = ^stage_d[0];
  assign bus.z_par  = stage_p[DEPTH];
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic_op_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (enable),
      .flush  (flush),
      .d_in   (stage_d[k]),
      .v_in   (stage_v[k]),
`ifdef LOGIC_OP_PIPE_PARITY_EN
      .p_in   (stage_p[k]),
      .p_out  (stage_p[k+1]),
`endif
      .d_out  (stage_d[k+1]),
      .v_out  (stage_v[k+1])
    );
  end

  assign bus.z         = stage_d[DEPTH];
  assign bus.out_valid = stage_v[DEPTH];

endmodule

// File: tb/tb_logic_op_pipe.sv
// Directed self-checking bench for logic_op_pipe (WIDTH=8, DEPTH=2).
// Parity checks are compiled in with LOGIC_OP_PIPE_PARITY_EN.
module tb_logic_op_pipe;
  import logic_op_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic flush;

  int checks   = 0;
  int failures = 0;

  logic_op_if #(.WIDTH(WIDTH)) bus ();

  logic_op_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       in_valid;
    logic_op_e  op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_z;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[13];

  task automatic apply_stimulus(input logic v, input logic_op_e o,
                                input logic [7:0] av, input logic [7:0] bv);
    bus.in_valid = v;
    bus.op       = o;
    bus.a        = av;
    bus.b        = bv;
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [7:0] exp_z,
                              input logic exp_valid);
    checks++;
    if (bus.z !== exp_z) begin
      failures++;
      $display("[TB] FAIL %s z: got %02h want %02h", name, bus.z, exp_z);
    end
    checks++;
    if (bus.out_valid !== exp_valid) begin
      failures++;
      $display("[TB] FAIL %s out_valid: got %b want %b", name, bus.out_valid, exp_valid);
    end
`ifdef LOGIC_OP_PIPE_PARITY_EN
    checks++;
    if (bus.z_par !== ^exp_z) begin
      failures++;
      $display("[TB] FAIL %s z_par: got %b want %b", name, bus.z_par, ^exp_z);
    end
`endif
  endtask

  initial begin
    // Each row: inputs sampled at this edge, and outputs expected just after it.
    vecs[0]  = '{1'b1, OP_AND,  8'hF0, 8'h3C, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, OP_OR,   8'hF0, 8'h3C, 8'h30, 1'b1};
    vecs[2]  = '{1'b1, OP_XOR,  8'hF0, 8'h3C, 8'hFC, 1'b1};
    vecs[3]  = '{1'b1, OP_NAND, 8'hF0, 8'h3C, 8'hCC, 1'b1};
    vecs[4]  = '{1'b0, OP_AND,  8'h00, 8'h00, 8'hCF, 1'b1};
    vecs[5]  = '{1'b1, OP_AND,  8'hFF, 8'h0F, 8'hCF, 1'b0};
    vecs[6]  = '{1'b1, OP_XOR,  8'hAA, 8'h55, 8'h0F, 1'b1};
    vecs[7]  = '{1'b0, OP_OR,   8'h12, 8'h34, 8'hFF, 1'b1};
    vecs[8]  = '{1'b0, OP_OR,   8'h12, 8'h34, 8'hFF, 1'b0};
    vecs[9]  = '{1'b1, OP_OR,   8'h03, 8'h04, 8'hFF, 1'b0};
    vecs[10] = '{1'b1, OP_AND,  8'h03, 8'h03, 8'h07, 1'b1};
    vecs[11] = '{1'b0, OP_AND,  8'h00, 8'h00, 8'h03, 1'b1};
    vecs[12] = '{1'b0, OP_AND,  8'h00, 8'h00, 8'h03, 1'b0};

    rst_n  = 1'b0;
    enable = 1'b0;
    flush  = 1'b0;
    apply_stimulus(1'b0, OP_AND, 8'h00, 8'h00);
    #12;
    check_output("reset", 8'h00, 1'b0);

    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i].in_valid, vecs[i].op, vecs[i].a, vecs[i].b);
      step();
      check_output($sformatf("vec%0d", i), vecs[i].exp_z, vecs[i].exp_valid);
    end

    // Stall with the beat sitting in stage 1: outputs frozen for three cycles.
    apply_stimulus(1'b1, OP_AND, 8'hFF, 8'h0F);
    step();
    enable = 1'b0;
    apply_stimulus(1'b0, OP_AND, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output($sformatf("stall%0d", i), 8'h03, 1'b0);
    end
    enable = 1'b1;
    step();
    check_output("stall_release", 8'h0F, 1'b1);
    step();
    check_output("stall_after", 8'h0F, 1'b0);

    // out_valid must hold high across a stall, then drop on the next enabled edge.
    apply_stimulus(1'b1, OP_OR, 8'hF0, 8'h0F);
    step();
    apply_stimulus(1'b0, OP_AND, 8'h00, 8'h00);
    step();
    check_output("hold_valid0", 8'hFF, 1'b1);
    enable = 1'b0;
    step();
    check_output("hold_valid1", 8'hFF, 1'b1);
    step();
    check_output("hold_valid2", 8'hFF, 1'b1);
    enable = 1'b1;
    step();
    check_output("hold_valid_end", 8'hFF, 1'b0);

    // Flush with two beats in flight; a beat presented alongside it is dropped.
    apply_stimulus(1'b1, OP_XOR, 8'h0F, 8'h01);
    step();
    apply_stimulus(1'b1, OP_AND, 8'hF0, 8'hF0);
    step();
    check_output("pre_flush", 8'h0E, 1'b1);
    flush  = 1'b1;
    enable = 1'b0;
    apply_stimulus(1'b1, OP_OR, 8'hFF, 8'hFF);
    step();
    check_output("flush", 8'h0E, 1'b0);
    flush  = 1'b0;
    enable = 1'b1;
    apply_stimulus(1'b0, OP_AND, 8'h00, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check_output($sformatf("post_flush%0d", i), 8'h0E, 1'b0);
    end

    // Asynchronous reset mid-stream clears outputs before the next edge.
    apply_stimulus(1'b1, OP_OR, 8'h55, 8'hAA);
    step();
    apply_stimulus(1'b1, OP_AND, 8'h0F, 8'h0F);
    step();
    check_output("pre_reset", 8'hFF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b0, OP_AND, 8'h00, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check_output($sformatf("post_reset%0d", i), 8'h00, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
